// File: rtl/regfile_wport_ctrl_if.sv
// Bundle between the register-file write-port controller and its clients.
// Carries writeback requests, reservations, hazard checks and the regfile write port.
interface regfile_wport_ctrl_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rsv_valid;
    logic [AW-1:0]      rsv_addr;
    logic [AW-1:0]      chk_addr1;
    logic [AW-1:0]      chk_addr2;
    logic               chk_busy1;
    logic               chk_busy2;
    logic               init_done;
    logic               rf_we;
    logic [AW-1:0]      rf_writeaddr;
    logic [DW-1:0]      rf_writedata;

    modport slave (
        input  req_valid, req_addr, req_data,
        input  rsv_valid, rsv_addr, chk_addr1, chk_addr2,
        output req_ready, chk_busy1, chk_busy2, init_done,
        output rf_we, rf_writeaddr, rf_writedata
    );

    modport master (
        output req_valid, req_addr, req_data,
        output rsv_valid, rsv_addr, chk_addr1, chk_addr2,
        input  req_ready, chk_busy1, chk_busy2, init_done,
        input  rf_we, rf_writeaddr, rf_writedata
    );
endinterface

// File: rtl/regfile_wport_ctrl.sv
// Write-port controller for the 32x32 regfile: zero-fill after reset, then
// round-robin writeback arbitration plus a pending-write scoreboard.
// Ports: clk, rst (async, active high), bus (slave side of the write-port bundle).
module regfile_wport_ctrl #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input logic clk,
    input logic rst,
    regfile_wport_ctrl_if.slave bus
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [LW-1:0]   last;
    logic [31:0]     busy;
    logic            we_q;
    logic [AW-1:0]   waddr_q;
    logic [DW-1:0]   wdata_q;

    logic [NREQ-1:0] gnt;
    logic [LW-1:0]   gidx;
    logic [LW-1:0]   ci;
    logic            found;
    logic            xfer;
    logic [AW-1:0]   gaddr;
    logic [DW-1:0]   gdata;
    logic [31:0]     busy_nxt;

    // Rotating priority: start the search just after the last winner.
    always_comb begin
        gnt   = '0;
        gidx  = last;
        ci    = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            ci = LW'((int'(last) + k) % NREQ);
            if (!found && state == RUN && bus.req_valid[ci]) begin
                gnt[ci] = 1'b1;
                gidx    = ci;
                found   = 1'b1;
            end
        end
    end

    assign xfer = |gnt;

    always_comb begin
        gaddr = '0;
        gdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gaddr = bus.req_addr[i*AW +: AW];
                gdata = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Set beats clear on the same address so a reissued register stays pending.
    always_comb begin
        busy_nxt = busy;
        if (xfer)
            busy_nxt[gaddr] = 1'b0;
        if (bus.rsv_valid && bus.rsv_addr != '0)
            busy_nxt[bus.rsv_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= '0;
            last    <= LAST_RST;
            busy    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                INIT: begin
                    we_q    <= 1'b1;
                    waddr_q <= cnt;
                    wdata_q <= '0;
                    cnt     <= cnt + 1'b1;
                    busy    <= '0;
                    if (cnt == AW'(31))
                        state <= RUN;
                end
                RUN: begin
                    busy <= busy_nxt;
                    // r0 writes are consumed but never reach the regfile.
                    we_q <= xfer && gaddr != '0;
                    if (xfer) begin
                        last <= gidx;
                        if (gaddr != '0) begin
                            waddr_q <= gaddr;
                            wdata_q <= gdata;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.req_ready    = gnt;
    assign bus.init_done    = (state == RUN);
    assign bus.chk_busy1    = (state == INIT) | busy[bus.chk_addr1];
    assign bus.chk_busy2    = (state == INIT) | busy[bus.chk_addr2];
    assign bus.rf_we        = we_q;
    assign bus.rf_writeaddr = waddr_q;
    assign bus.rf_writedata = wdata_q;
endmodule

// File: tb/tb_regfile_wport_ctrl.sv
// Directed-vector bench for regfile_wport_ctrl.
// Drives the bundle through zero-fill, arbitration, scoreboard and reset cases.
module tb_regfile_wport_ctrl;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [DW-1:0] mem [32];

    regfile_wport_ctrl_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    regfile_wport_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model with write-before-read bypass.
    always @(posedge clk)
        if (bus.rf_we) mem[bus.rf_writeaddr] <= bus.rf_writedata;

    function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] a);
        if (bus.rf_we && bus.rf_writeaddr == a) return bus.rf_writedata;
        return mem[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i] = v;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g [4];
        g = '{0, 1, 2, 0};
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = '0;
        bus.chk_addr1 = '0;
        bus.chk_addr2 = '0;
        #2;
        check("rst_we", 32'(bus.rf_we), 0);
        check("rst_addr", 32'(bus.rf_writeaddr), 0);
        check("rst_data", bus.rf_writedata, 0);
        check("rst_done", 32'(bus.init_done), 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_busy1", 32'(bus.chk_busy1), 1);
        check("rst_busy2", 32'(bus.chk_busy2), 1);
        #10 rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            tick();
            check("fill_we", 32'(bus.rf_we), 1);
            check("fill_addr", 32'(bus.rf_writeaddr), i);
            check("fill_data", bus.rf_writedata, 0);
            check("fill_done", 32'(bus.init_done), (i == 31) ? 1 : 0);
            check("fill_busy1", 32'(bus.chk_busy1), (i == 31) ? 0 : 1);
        end

        set_req(0, 1'b1, 5'd5, 32'hA);
        set_req(1, 1'b1, 5'd6, 32'hB);
        set_req(2, 1'b1, 5'd7, 32'hC);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rr_ready", 32'(bus.req_ready), 32'(1) << g[k]);
            tick();
            check("rr_we", 32'(bus.rf_we), 1);
            check("rr_addr", 32'(bus.rf_writeaddr), 5 + g[k]);
            check("rr_data", bus.rf_writedata, 32'hA + g[k]);
        end
        bus.req_valid = '0;
        tick();
        check("idle_we", 32'(bus.rf_we), 0);
        check("idle_addr_hold", 32'(bus.rf_writeaddr), 5);
        check("fill_mem31", rf_read(5'd31), 0);

        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd9;
        bus.chk_addr1 = 5'd9;
        tick();
        bus.rsv_valid = 1'b0;
        check("r9_busy", 32'(bus.chk_busy1), 1);
        set_req(1, 1'b1, 5'd9, 32'h1234);
        #1;
        check("r9_ready", 32'(bus.req_ready), 3'b010);
        tick();
        bus.req_valid = '0;
        check("r9_we", 32'(bus.rf_we), 1);
        check("r9_addr", 32'(bus.rf_writeaddr), 9);
        check("r9_busy_clr", 32'(bus.chk_busy1), 0);
        check("r9_bypass", rf_read(5'd9), 32'h1234);

        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd4;
        bus.chk_addr2 = 5'd4;
        set_req(2, 1'b1, 5'd4, 32'h44);
        #1;
        check("r4_ready", 32'(bus.req_ready), 3'b100);
        tick();
        bus.rsv_valid = 1'b0;
        bus.req_valid = '0;
        check("r4_set_wins", 32'(bus.chk_busy2), 1);
        check("r4_data", bus.rf_writedata, 32'h44);
        set_req(0, 1'b1, 5'd4, 32'h45);
        tick();
        bus.req_valid = '0;
        check("r4_clr", 32'(bus.chk_busy2), 0);

        set_req(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("r0_ready", 32'(bus.req_ready), 3'b001);
        tick();
        bus.req_valid = '0;
        check("r0_we", 32'(bus.rf_we), 0);
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd0;
        bus.chk_addr1 = 5'd0;
        tick();
        bus.rsv_valid = 1'b0;
        check("r0_busy", 32'(bus.chk_busy1), 0);

        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd3;
        bus.chk_addr1 = 5'd3;
        tick();
        bus.rsv_valid = 1'b0;
        check("r3_busy", 32'(bus.chk_busy1), 1);
        set_req(0, 1'b1, 5'd10, 32'h10);
        set_req(1, 1'b1, 5'd11, 32'h11);
        set_req(2, 1'b1, 5'd12, 32'h12);
        tick();
        tick();
        tick();
        check("burst_we", 32'(bus.rf_we), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_we", 32'(bus.rf_we), 0);
        check("mid_addr", 32'(bus.rf_writeaddr), 0);
        check("mid_data", bus.rf_writedata, 0);
        check("mid_done", 32'(bus.init_done), 0);
        check("mid_ready", 32'(bus.req_ready), 0);
        check("mid_busy1", 32'(bus.chk_busy1), 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("refill_ready", 32'(bus.req_ready), 0);
            tick();
            check("refill_addr", 32'(bus.rf_writeaddr), i);
        end
        check("re_done", 32'(bus.init_done), 1);
        check("re_ready", 32'(bus.req_ready), 3'b001);
        check("re_busy_r3", 32'(bus.chk_busy1), 0);
        bus.req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
